// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the cache backend read path.
package cache_pkg;

  localparam int unsigned TAGS_WIDTH_DEF = 48;
  localparam int unsigned CACHE_SIZE_DEF = 512;

  // Read-arbiter FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational cyclic priority pick: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/backend_rd_arbiter.sv
// Round-robin arbiter funnelling per-way cache-line reads into a single
// backend stream, one transaction in flight, with a backend-silence timeout.
module backend_rd_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TAGS_WIDTH     = TAGS_WIDTH_DEF,
  parameter int unsigned CACHE_SIZE     = CACHE_SIZE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_addr_tvalid,
  output logic [NUM_REQ-1:0]            req_addr_tready,
  input  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata,
  output logic [NUM_REQ-1:0]            rsp_data_tvalid,
  input  logic [NUM_REQ-1:0]            rsp_data_tready,
  output logic [CACHE_SIZE-1:0]         rsp_data_tdata,
  output logic                          rsp_err,
  output logic                          be_addr_tvalid,
  input  logic                          be_addr_tready,
  output logic [TAGS_WIDTH-1:0]         be_addr_tdata,
  input  logic                          be_data_tvalid,
  output logic                          be_data_tready,
  input  logic [CACHE_SIZE-1:0]         be_data_tdata,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]            state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  drain, drain_nxt;
  logic [IDX_W-1:0]      gid_nxt;
  logic [TAGS_WIDTH-1:0] tag_nxt, tag_sel;
  logic [CACHE_SIZE-1:0] line_nxt;
  logic                  err_nxt;
  logic [NUM_REQ-1:0]    rsp_vld_nxt;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_addr_tvalid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Tag of the winning requester, AND-OR mux over the one-hot grant
  always_comb begin
    tag_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) tag_sel = tag_sel | req_addr_tdata[i*TAGS_WIDTH +: TAGS_WIDTH];
    end
  end

  // Accept strobe must land in the same cycle as the pick, so it stays combinational
  assign req_addr_tready = (state == ST_IDLE && !rst) ? arb_grant : '0;

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    drain_nxt  = drain;
    gid_nxt    = grant_id;
    tag_nxt    = be_addr_tdata;
    line_nxt   = rsp_data_tdata;
    err_nxt    = rsp_err;

    // A beat seen while draining is the stale reply of a timed-out request
    if (drain && be_data_tvalid) drain_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          state_nxt  = ST_ISSUE;
          gid_nxt    = arb_idx;
          tag_nxt    = tag_sel;
          rr_ptr_nxt = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
        end
      end
      ST_ISSUE: begin
        if (be_addr_tready) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (be_data_tvalid && !drain) begin
          state_nxt = ST_DELIVER;
          line_nxt  = be_data_tdata;
          err_nxt   = 1'b0;
        end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_MAX) begin
          state_nxt = ST_DELIVER;
          line_nxt  = '0;
          err_nxt   = 1'b1;
          drain_nxt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DELIVER: begin
        if (rsp_data_tready[grant_id]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    rsp_vld_nxt = '0;
    if (state_nxt == ST_DELIVER) rsp_vld_nxt[gid_nxt] = 1'b1;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      cnt             <= '0;
      drain           <= 1'b0;
      grant_id        <= '0;
      be_addr_tdata   <= '0;
      rsp_data_tdata  <= '0;
      rsp_err         <= 1'b0;
      rsp_data_tvalid <= '0;
      be_addr_tvalid  <= 1'b0;
      be_data_tready  <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nxt;
      rr_ptr          <= rr_ptr_nxt;
      cnt             <= cnt_nxt;
      drain           <= drain_nxt;
      grant_id        <= gid_nxt;
      be_addr_tdata   <= tag_nxt;
      rsp_data_tdata  <= line_nxt;
      rsp_err         <= err_nxt;
      rsp_data_tvalid <= rsp_vld_nxt;
      be_addr_tvalid  <= (state_nxt == ST_ISSUE);
      be_data_tready  <= (state_nxt == ST_WAIT) || drain_nxt;
      busy            <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_backend_rd_arbiter.sv
// Directed-plus-random bench for backend_rd_arbiter against a transaction-level model.
module tb_backend_rd_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TW  = 48;
  localparam int unsigned CW  = 512;
  localparam int unsigned TMO = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_addr_tvalid;
  logic [N-1:0]    req_addr_tready;
  logic [N*TW-1:0] req_addr_tdata;
  logic [N-1:0]    rsp_data_tvalid;
  logic [N-1:0]    rsp_data_tready;
  logic [CW-1:0]   rsp_data_tdata;
  logic            rsp_err;
  logic            be_addr_tvalid;
  logic            be_addr_tready;
  logic [TW-1:0]   be_addr_tdata;
  logic            be_data_tvalid;
  logic            be_data_tready;
  logic [CW-1:0]   be_data_tdata;
  logic            busy;
  logic [1:0]      grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: round-robin pointer, pending stale beat, per-requester tags
  int            m_ptr;
  bit            m_drain;
  logic [TW-1:0] tags [N];

  backend_rd_arbiter #(
    .NUM_REQ        (N),
    .TAGS_WIDTH     (TW),
    .CACHE_SIZE     (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_addr_tvalid (req_addr_tvalid),
    .req_addr_tready (req_addr_tready),
    .req_addr_tdata  (req_addr_tdata),
    .rsp_data_tvalid (rsp_data_tvalid),
    .rsp_data_tready (rsp_data_tready),
    .rsp_data_tdata  (rsp_data_tdata),
    .rsp_err         (rsp_err),
    .be_addr_tvalid  (be_addr_tvalid),
    .be_addr_tready  (be_addr_tready),
    .be_addr_tdata   (be_addr_tdata),
    .be_data_tvalid  (be_data_tvalid),
    .be_data_tready  (be_data_tready),
    .be_data_tdata   (be_data_tdata),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [CW-1:0] rand_line();
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_tag();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic drive_tags();
    for (int j = 0; j < N; j++) req_addr_tdata[j*TW +: TW] = tags[j];
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_req_rdy"},  CW'(req_addr_tready), '0);
    chk({p, "_rsp_vld"},  CW'(rsp_data_tvalid), '0);
    chk({p, "_rsp_data"}, rsp_data_tdata,       '0);
    chk({p, "_rsp_err"},  CW'(rsp_err),         '0);
    chk({p, "_be_avld"},  CW'(be_addr_tvalid),  '0);
    chk({p, "_be_adata"}, CW'(be_addr_tdata),   '0);
    chk({p, "_be_drdy"},  CW'(be_data_tready),  '0);
    chk({p, "_busy"},     CW'(busy),            '0);
    chk({p, "_gid"},      CW'(grant_id),        '0);
  endtask

  // One full read transaction; starts and ends just after a falling edge with the DUT idle
  task automatic txn(input logic [N-1:0] vmask, input int s_addr, input int d_data,
                     input int s_rsp, input logic [CW-1:0] line, input bit silent);
    int            g;
    int            first_real;
    int            beat_it;
    int            deliver_it;
    bit            stale_todo;
    bit            done;
    logic [N-1:0]  oh;
    logic [CW-1:0] exp_line;
    logic          exp_err;

    g  = rr_pick(vmask, m_ptr);
    oh = N'(1) << g;
    drive_tags();
    req_addr_tvalid = vmask;
    #1;
    chk("req_tready",     CW'(req_addr_tready), CW'(oh));
    chk("idle_busy",      CW'(busy),            '0);
    chk("idle_drain_rdy", CW'(be_data_tready),  CW'(m_drain));
    m_ptr = (g + 1) % N;

    for (int i = 0; i <= s_addr; i++) begin
      @(negedge clk);
      req_addr_tvalid = vmask & ~oh;
      be_addr_tready  = (i == s_addr);
      #1;
      chk("addr_valid",     CW'(be_addr_tvalid),  CW'(1'b1));
      chk("addr_data",      CW'(be_addr_tdata),   CW'(tags[g]));
      chk("addr_gid",       CW'(grant_id),        CW'(g));
      chk("addr_req_rdy",   CW'(req_addr_tready), '0);
      chk("addr_drain_rdy", CW'(be_data_tready),  CW'(m_drain));
      chk("addr_busy",      CW'(busy),            CW'(1'b1));
    end

    stale_todo = m_drain;
    first_real = 0;
    beat_it    = -1;
    deliver_it = -1;
    done       = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      be_addr_tready = 1'($urandom_range(0, 1));
      be_data_tvalid = 1'b0;
      be_data_tdata  = CW'($urandom);
      #1;
      if (rsp_data_tvalid != '0) begin
        done       = 1'b1;
        deliver_it = i;
      end else begin
        chk("wait_addr_once", CW'(be_addr_tvalid),  '0);
        chk("wait_data_rdy",  CW'(be_data_tready),  CW'(1'b1));
        chk("wait_req_rdy",   CW'(req_addr_tready), '0);
        if (stale_todo) begin
          be_data_tvalid = 1'b1;
          be_data_tdata  = ~line;
          stale_todo     = 1'b0;
          m_drain        = 1'b0;
          first_real     = i + 1;
        end else if (!silent && i == first_real + d_data) begin
          be_data_tvalid = 1'b1;
          be_data_tdata  = line;
          beat_it        = i;
        end
      end
    end
    chk("deliver_seen", CW'(done), CW'(1'b1));
    if (!done) $fatal(1, "FAIL deliver_bound: no response within cycle budget");
    if (silent)
      chk("timeout_lat", CW'(deliver_it == TMO || deliver_it == TMO + 1), CW'(1'b1));
    else
      chk("deliver_lat", CW'(deliver_it), CW'(beat_it + 1));

    exp_err  = silent;
    exp_line = silent ? '0 : line;
    for (int i = 0; i <= s_rsp; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk("rsp_valid",   CW'(rsp_data_tvalid), CW'(oh));
      chk("rsp_data",    rsp_data_tdata,       exp_line);
      chk("rsp_err",     CW'(rsp_err),         CW'(exp_err));
      chk("rsp_busy",    CW'(busy),            CW'(1'b1));
      chk("rsp_req_rdy", CW'(req_addr_tready), '0);
      chk("rsp_gid",     CW'(grant_id),        CW'(g));
      rsp_data_tready = (i == s_rsp) ? (N'($urandom) | oh) : (N'($urandom) & ~oh);
    end

    @(negedge clk);
    rsp_data_tready = '0;
    req_addr_tvalid = '0;
    #1;
    chk("done_rsp_valid", CW'(rsp_data_tvalid), '0);
    chk("done_busy",      CW'(busy),            '0);
    if (silent) m_drain = 1'b1;
    tags[g] = rand_tag();
  endtask

  initial begin
    logic [N-1:0] vm;
    rst             = 1'b1;
    req_addr_tvalid = '0;
    req_addr_tdata  = '0;
    rsp_data_tready = '0;
    be_addr_tready  = 1'b0;
    be_data_tvalid  = 1'b0;
    be_data_tdata   = '0;
    m_ptr           = 0;
    m_drain         = 1'b0;
    for (int j = 0; j < N; j++) tags[j] = rand_tag();
    drive_tags();
    req_addr_tvalid = '1;

    // Reset state with every requester asking
    @(negedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    rst             = 1'b0;
    req_addr_tvalid = '0;
    #1;

    // All requesters busy from reset: grants 0,1,2,3,0
    for (int i = 0; i < 5; i++) txn(4'hF, 0, 0, 0, rand_line(), 1'b0);

    // Requester 2, tag 0x1234, 0xAB line, minimum latency
    tags[2] = 48'h1234;
    txn(4'b0100, 0, 0, 0, {64{8'hAB}}, 1'b0);

    // Backend address channel stalled for 5 cycles
    txn(4'b0001, 5, 0, 0, rand_line(), 1'b0);

    // Requester 1 stalls its response 10 cycles while others wait
    txn(4'hF, 0, 1, 10, rand_line(), 1'b0);

    // Silent backend times out; its late beat is discarded by the next request
    txn(4'b0100, 0, 0, 2, rand_line(), 1'b1);
    txn(4'b0010, 1, 2, 0, rand_line(), 1'b0);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      vm = N'($urandom);
      if (vm == '0) vm = 4'b1000;
      txn(vm, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
          rand_line(), ($urandom_range(0, 7) == 0));
    end

    // Reset while waiting for backend data
    req_addr_tvalid = 4'b0100;
    drive_tags();
    #1;
    chk("rw_req_rdy", CW'(req_addr_tready), CW'(4'b0100));
    @(negedge clk);
    req_addr_tvalid = '0;
    be_addr_tready  = 1'b1;
    #1;
    chk("rw_addr_valid", CW'(be_addr_tvalid), CW'(1'b1));
    @(negedge clk);
    be_addr_tready = 1'b0;
    #1;
    chk("rw_wait_rdy", CW'(be_data_tready), CW'(1'b1));
    rst = 1'b1;
    #1;
    chk_zero("rst_wait");
    req_addr_tvalid = '1;
    #1;
    chk("rst_req_rdy", CW'(req_addr_tready), '0);
    @(negedge clk);
    rst             = 1'b0;
    req_addr_tvalid = '0;
    m_ptr           = 0;
    m_drain         = 1'b0;
    #1;
    txn(4'hF, 0, 0, 0, rand_line(), 1'b0);
    txn(4'hF, 1, 0, 1, rand_line(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/backend_rd_arbiter.md
BACKEND_RD_ARBITER -- requirements
Module: backend_rd_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_REQ, 4, number of requesting cache ways (2..16).
- TAGS_WIDTH, 48, address/tag width.
- CACHE_SIZE, 512, cache-line data width.
- TIMEOUT_CYCLES, 1024, max cycles waiting for backend data; 0 disables the timeout.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_addr_tvalid  in  NUM_REQ  per-requester read request valid.
- req_addr_tready  out  NUM_REQ  per-requester request accept.
- req_addr_tdata  in  NUM_REQ*TAGS_WIDTH  request tags; requester i uses slice i.
- rsp_data_tvalid  out  NUM_REQ  per-requester response valid.
- rsp_data_tready  in  NUM_REQ  per-requester response accept.
- rsp_data_tdata  out  CACHE_SIZE  response line, shared by all requesters.
- rsp_err  out  1  response is a timeout error; qualified by rsp_data_tvalid.
- be_addr_tvalid / be_addr_tready / be_addr_tdata  out / in / out  1 / 1 / TAGS_WIDTH  backend request stream.
- be_data_tvalid / be_data_tready / be_data_tdata  in / out / in  1 / 1 / CACHE_SIZE  backend response stream.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the requester currently being served.

Function
REQ-003 The block SHALL be an FSM with states IDLE, ISSUE, WAIT, DELIVER, with exactly one backend transaction outstanding at a time.
REQ-004 IDLE: when any req_addr_tvalid is high, the block SHALL grant the first valid index at or after rr_ptr (cyclic), assert req_addr_tready for that index only in the same cycle, latch its tag and index, set rr_ptr to grant+1 mod NUM_REQ, and go to ISSUE.
REQ-005 req_addr_tready SHALL be low in every state other than IDLE; requests arriving while busy SHALL be held off, never dropped.
REQ-006 ISSUE: be_addr_tvalid SHALL be 1 with be_addr_tdata equal to the latched tag, stable until be_addr_tready; on that handshake the block SHALL go to WAIT and clear the timeout counter.
REQ-007 WAIT: be_data_tready SHALL be 1; on be_data_tvalid the block SHALL register be_data_tdata, set rsp_err=0, and go to DELIVER.
REQ-008 WAIT timeout: when TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with no beat, the block SHALL go to DELIVER with rsp_err=1, rsp_data_tdata=0, and set drain_pending.
REQ-009 While drain_pending=1, be_data_tready SHALL be 1 in every state; the next backend beat SHALL be discarded and clear drain_pending; a beat arriving in WAIT while drain_pending=1 SHALL be treated as the stale beat, not captured.
REQ-010 DELIVER: rsp_data_tvalid[grant_id] SHALL be 1 with data and rsp_err stable until rsp_data_tready[grant_id]; then the block SHALL return to IDLE, and no grant occurs in that cycle.
REQ-011 Minimum latency, from request handshake (cycle 0) with backend always ready and data returned one cycle after the address: be_addr_tvalid at cycle 1, data captured at cycle 2, rsp_data_tvalid at cycle 3.
REQ-012 rr_ptr SHALL wrap from NUM_REQ-1 to 0; a single persistent requester SHALL be re-granted on every IDLE visit.
REQ-013 The timeout counter SHALL be clog2(TIMEOUT_CYCLES+1) bits and SHALL saturate, never wrap.

Reset
REQ-014 rst SHALL asynchronously force IDLE, rr_ptr=0, drain_pending=0, counter=0 and all outputs (tvalids, treadys, tdata, rsp_err, busy, grant_id) to 0, including mid-transaction; the in-flight request is abandoned.

Structure
REQ-015 A shared package cache_pkg SHALL hold the FSM state enum and the default TAGS_WIDTH/CACHE_SIZE constants.
REQ-016 The cyclic grant selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant and index).

Verification
REQ-017 Single request, requester 2 tag 0x1234, backend returns 0xAB..AB one cycle later -> rsp_data_tvalid[2] at cycle 3 with that data, rsp_err=0.
REQ-018 All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; no requester is served twice before every other requester has been served once.
REQ-019 be_addr_tready held low 5 cycles -> be_addr_tvalid and be_addr_tdata stay stable for all 5 cycles, with exactly one address handshake.
REQ-020 TIMEOUT_CYCLES=8, backend silent -> error response (rsp_err=1, data 0) delivered to the requester; a late beat is then discarded, and the next request receives its own beat.
REQ-021 rst asserted in WAIT -> all outputs 0 in the same cycle, and the next request is granted starting from index 0.
REQ-022 rsp_data_tready[1] held low 10 cycles in DELIVER -> response held stable, other requests not accepted, busy=1 throughout.
